// File: rtl/radar_frame_peak_detect.sv
// Frame peak detector for the radar stream bus: per-lane approximate magnitude,
// running peak with location, threshold detection count, one result per frame.
module radar_frame_peak_detect #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 5,
    parameter int CNT_W      = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            data_vaild,
    input  logic                            data_start,
    input  logic                            data_end,
    input  logic [10:0]                     row_idx1,
    input  logic [10:0]                     col_idx1,
    input  logic [3:0]                      channel_num,
    input  logic [DATA_WIDTH*LANES*2-1:0]   pixel_out,
    input  logic [DATA_WIDTH:0]             threshold,
    output logic                            busy,
    output logic                            peak_valid,
    output logic [DATA_WIDTH:0]             peak_mag,
    output logic [10:0]                     peak_row,
    output logic [10:0]                     peak_col,
    output logic [2:0]                      peak_lane,
    output logic [3:0]                      peak_channel,
    output logic [CNT_W-1:0]                beat_count,
    output logic [CNT_W-1:0]                det_count,
    output logic                            frame_err
);

    localparam int MW   = DATA_WIDTH + 1;
    localparam int PW   = DATA_WIDTH * LANES * 2;
    localparam int PC_W = $clog2(LANES + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state;
    logic   err_flag;
    logic [3:0] chan;

    logic accept;
    logic beat_err;
    logic [3:0] beat_ch;

    // Stage 0: registered accepted beat
    logic            s0_valid, s0_first, s0_last, s0_err;
    logic [PW-1:0]   s0_pix;
    logic [10:0]     s0_row, s0_col;
    logic [3:0]      s0_ch;

    // Stage 1: absolute values
    logic                  s1_valid, s1_first, s1_last, s1_err;
    logic [DATA_WIDTH-1:0] s1_abs_i [LANES];
    logic [DATA_WIDTH-1:0] s1_abs_q [LANES];
    logic [10:0]           s1_row, s1_col;
    logic [3:0]            s1_ch;

    // Stage 2: magnitudes and threshold flags
    logic              s2_valid, s2_first, s2_last, s2_err;
    logic [MW-1:0]     s2_mag [LANES];
    logic [LANES-1:0]  s2_over;
    logic [10:0]       s2_row, s2_col;
    logic [3:0]        s2_ch;

    logic [MW-1:0]     mag_c [LANES];
    logic [LANES-1:0]  over_c;

    // Running frame accumulators
    logic [MW-1:0]     acc_mag;
    logic [10:0]       acc_row, acc_col;
    logic [2:0]        acc_lane;
    logic [CNT_W-1:0]  acc_beat, acc_det;

    logic [MW-1:0]     best_mag;
    logic [2:0]        best_lane;
    logic [PC_W-1:0]   pop;
    logic [CNT_W:0]    det_sum;
    logic [MW-1:0]     nxt_mag;
    logic [10:0]       nxt_row, nxt_col;
    logic [2:0]        nxt_lane;
    logic [CNT_W-1:0]  nxt_beat, nxt_det;

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    // A restart while a frame is open flags the frame; a start from IDLE clears it.
    assign accept   = data_vaild & (data_start | (state == ACTIVE));
    assign beat_err = data_start ? (state == ACTIVE) : err_flag;
    assign beat_ch  = data_start ? channel_num : chan;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            err_flag <= 1'b0;
            chan     <= '0;
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_err   <= 1'b0;
            s0_pix   <= '0;
            s0_row   <= '0;
            s0_col   <= '0;
            s0_ch    <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                state    <= data_end ? IDLE : ACTIVE;
                err_flag <= beat_err;
                chan     <= beat_ch;
                s0_first <= data_start;
                s0_last  <= data_end;
                s0_err   <= beat_err;
                s0_pix   <= pixel_out;
                s0_row   <= row_idx1;
                s0_col   <= col_idx1;
                s0_ch    <= beat_ch;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_ch    <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_abs_i[k] <= '0;
                s1_abs_q[k] <= '0;
            end
        end else begin
            s1_valid <= s0_valid;
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_err   <= s0_err;
            s1_row   <= s0_row;
            s1_col   <= s0_col;
            s1_ch    <= s0_ch;
            for (int k = 0; k < LANES; k++) begin
                s1_abs_i[k] <= abs_val(s0_pix[k*2*DATA_WIDTH +: DATA_WIDTH]);
                s1_abs_q[k] <= abs_val(s0_pix[k*2*DATA_WIDTH+DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // max + min/2 fits in DATA_WIDTH+1 bits since both inputs are at most 2^(W-1).
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            mag_c[k] = '0;
            if (s1_abs_i[k] >= s1_abs_q[k])
                mag_c[k] = MW'(s1_abs_i[k]) + MW'(s1_abs_q[k] >> 1);
            else
                mag_c[k] = MW'(s1_abs_q[k]) + MW'(s1_abs_i[k] >> 1);
            over_c[k] = mag_c[k] > threshold;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_err   <= 1'b0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_ch    <= '0;
            s2_over  <= '0;
            for (int k = 0; k < LANES; k++)
                s2_mag[k] <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_err   <= s1_err;
            s2_row   <= s1_row;
            s2_col   <= s1_col;
            s2_ch    <= s1_ch;
            s2_over  <= over_c;
            for (int k = 0; k < LANES; k++)
                s2_mag[k] <= mag_c[k];
        end
    end

    // Strict comparisons let the lowest lane and the earliest beat win ties.
    always_comb begin
        best_mag  = s2_mag[0];
        best_lane = 3'd0;
        pop       = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s2_mag[k] > best_mag) begin
                best_mag  = s2_mag[k];
                best_lane = 3'(k);
            end
            pop = pop + PC_W'(s2_over[k]);
        end

        det_sum  = {1'b0, acc_det} + (CNT_W+1)'(pop);
        nxt_mag  = acc_mag;
        nxt_row  = acc_row;
        nxt_col  = acc_col;
        nxt_lane = acc_lane;
        nxt_beat = (acc_beat == {CNT_W{1'b1}}) ? acc_beat : acc_beat + 1'b1;
        nxt_det  = det_sum[CNT_W] ? {CNT_W{1'b1}} : det_sum[CNT_W-1:0];

        if (s2_first) begin
            nxt_mag  = best_mag;
            nxt_row  = s2_row;
            nxt_col  = s2_col;
            nxt_lane = best_lane;
            nxt_beat = CNT_W'(1);
            nxt_det  = CNT_W'(pop);
        end else if (best_mag > acc_mag) begin
            nxt_mag  = best_mag;
            nxt_row  = s2_row;
            nxt_col  = s2_col;
            nxt_lane = best_lane;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_mag      <= '0;
            acc_row      <= '0;
            acc_col      <= '0;
            acc_lane     <= '0;
            acc_beat     <= '0;
            acc_det      <= '0;
            peak_valid   <= 1'b0;
            peak_mag     <= '0;
            peak_row     <= '0;
            peak_col     <= '0;
            peak_lane    <= '0;
            peak_channel <= '0;
            beat_count   <= '0;
            det_count    <= '0;
            frame_err    <= 1'b0;
        end else begin
            peak_valid <= s2_valid & s2_last;
            if (s2_valid) begin
                acc_mag  <= nxt_mag;
                acc_row  <= nxt_row;
                acc_col  <= nxt_col;
                acc_lane <= nxt_lane;
                acc_beat <= nxt_beat;
                acc_det  <= nxt_det;
            end
            if (s2_valid && s2_last) begin
                peak_mag     <= nxt_mag;
                peak_row     <= nxt_row;
                peak_col     <= nxt_col;
                peak_lane    <= nxt_lane;
                peak_channel <= s2_ch;
                beat_count   <= nxt_beat;
                det_count    <= nxt_det;
                frame_err    <= s2_err;
            end
        end
    end

    assign busy = (state == ACTIVE) | s0_valid | s1_valid | s2_valid;

endmodule

// File: tb/tb_radar_frame_peak_detect.sv
// Directed bench for radar_frame_peak_detect: expected frame results are queued
// as frames are driven and checked by an independent monitor on peak_valid.
module tb_radar_frame_peak_detect;

    localparam int W  = 16;
    localparam int L  = 5;
    localparam int CW = 16;
    localparam int PW = W * L * 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          data_vaild, data_start, data_end;
    logic [10:0]   row_idx1, col_idx1;
    logic [3:0]    channel_num;
    logic [PW-1:0] pixel_out;
    logic [W:0]    threshold;
    logic          busy, peak_valid, frame_err;
    logic [W:0]    peak_mag;
    logic [10:0]   peak_row, peak_col;
    logic [2:0]    peak_lane;
    logic [3:0]    peak_channel;
    logic [CW-1:0] beat_count, det_count;

    radar_frame_peak_detect #(.DATA_WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .data_vaild(data_vaild),
        .data_start(data_start), .data_end(data_end), .row_idx1(row_idx1),
        .col_idx1(col_idx1), .channel_num(channel_num), .pixel_out(pixel_out),
        .threshold(threshold), .busy(busy), .peak_valid(peak_valid),
        .peak_mag(peak_mag), .peak_row(peak_row), .peak_col(peak_col),
        .peak_lane(peak_lane), .peak_channel(peak_channel),
        .beat_count(beat_count), .det_count(det_count), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] mag, row, col, lane, ch, beat, det, err, cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cycle  = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] set_lane(input logic [PW-1:0] p, input int k,
                                               input int i, input int q);
        logic [PW-1:0] r;
        r = p;
        r[k*2*W +: W]     = W'(i);
        r[k*2*W + W +: W] = W'(q);
        return r;
    endfunction

    function automatic logic [PW-1:0] all_lanes(input int i, input int q);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) r = set_lane(r, k, i, q);
        return r;
    endfunction

    // Drives one beat and returns the clock edge count at which it was sampled.
    task automatic apply_stimulus(input logic v, input logic s, input logic e,
                                  input int row, input int col, input int ch,
                                  input logic [PW-1:0] pix, output int acc_cyc);
        data_vaild  = v;
        data_start  = s;
        data_end    = e;
        row_idx1    = 11'(row);
        col_idx1    = 11'(col);
        channel_num = 4'(ch);
        pixel_out   = pix;
        @(posedge clock);
        #1;
        acc_cyc = cycle;
    endtask

    task automatic idle_cycles(input int n, input bit garbage);
        for (int j = 0; j < n; j++) begin
            data_vaild = 1'b0;
            if (garbage) begin
                data_start  = 1'($urandom_range(0, 1));
                data_end    = 1'($urandom_range(0, 1));
                row_idx1    = 11'($urandom);
                col_idx1    = 11'($urandom);
                channel_num = 4'($urandom);
                pixel_out   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input int mag, input int row, input int col, input int lane,
                            input int ch, input int beat, input int det, input int err,
                            input int end_cyc);
        exp_t e;
        e.mag = mag; e.row = row; e.col = col; e.lane = lane; e.ch = ch;
        e.beat = beat; e.det = det; e.err = err; e.cyc = end_cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_peak_valid"}, 32'(peak_valid), 0);
        check_output({tag, "_peak_mag"},   32'(peak_mag), 0);
        check_output({tag, "_peak_row"},   32'(peak_row), 0);
        check_output({tag, "_beat_count"}, 32'(beat_count), 0);
        check_output({tag, "_det_count"},  32'(det_count), 0);
        check_output({tag, "_frame_err"},  32'(frame_err), 0);
        check_output({tag, "_busy"},       32'(busy), 0);
    endtask

    // Monitor: every peak_valid cycle consumes exactly one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (peak_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_peak: got peak_valid at cycle %0d, expected none (peak_mag %0d)",
                             cycle, peak_mag);
                end else begin
                    e = exp_q.pop_front();
                    check_output("latency",      32'(cycle),        e.cyc);
                    check_output("peak_mag",     32'(peak_mag),     e.mag);
                    check_output("peak_row",     32'(peak_row),     e.row);
                    check_output("peak_col",     32'(peak_col),     e.col);
                    check_output("peak_lane",    32'(peak_lane),    e.lane);
                    check_output("peak_channel", 32'(peak_channel), e.ch);
                    check_output("beat_count",   32'(beat_count),   e.beat);
                    check_output("det_count",    32'(det_count),    e.det);
                    check_output("frame_err",    32'(frame_err),    e.err);
                end
            end
        end
    end

    initial begin
        int c;
        logic [PW-1:0] pix;

        reset_n = 1'b0;
        data_vaild = 1'b0; data_start = 1'b0; data_end = 1'b0;
        row_idx1 = '0; col_idx1 = '0; channel_num = '0; pixel_out = '0;
        threshold = '0;
        repeat (3) @(posedge clock);
        #1;
        check_cleared("reset");
        reset_n = 1'b1;
        idle_cycles(2, 1'b0);

        // Single-beat frame
        threshold = 17'd100;
        apply_stimulus(1, 1, 1, 3, 7, 2, set_lane('0, 2, -300, 400), c);
        push_exp(550, 3, 7, 2, 2, 1, 1, 0, c);
        idle_cycles(6, 1'b0);

        // 8-beat frame with a full-scale negative sample, then a tie frame back-to-back
        threshold = 17'd0;
        for (int col = 0; col < 8; col++) begin
            pix = all_lanes(10, 0);
            if (col == 5) pix = set_lane(pix, 4, -32768, -32768);
            apply_stimulus(1, col == 0, col == 7, 1, col, 5, pix, c);
        end
        push_exp(49152, 1, 5, 4, 5, 8, 40, 0, c);
        pix = set_lane(set_lane('0, 1, 1000, 0), 3, 1000, 0);
        apply_stimulus(1, 1, 0, 9, 2, 1, pix, c);
        apply_stimulus(1, 0, 1, 10, 3, 1, pix, c);
        push_exp(1000, 9, 2, 1, 1, 2, 4, 0, c);
        idle_cycles(6, 1'b0);

        // Restart on beat 3, then a clean frame straight after
        threshold = 17'd100;
        apply_stimulus(1, 1, 0, 2, 1, 6, set_lane('0, 0, 5000, 0), c);
        check_output("busy_active", 32'(busy), 1);
        apply_stimulus(1, 0, 0, 2, 2, 6, set_lane('0, 0, 5000, 0), c);
        apply_stimulus(1, 1, 0, 2, 3, 6, '0, c);
        apply_stimulus(1, 0, 0, 2, 4, 6, set_lane('0, 2, 0, 200), c);
        apply_stimulus(1, 0, 1, 2, 5, 6, '0, c);
        push_exp(200, 2, 4, 2, 6, 3, 1, 1, c);
        apply_stimulus(1, 1, 1, 2, 9, 7, set_lane('0, 1, 50, -120), c);
        push_exp(145, 2, 9, 1, 7, 1, 1, 0, c);
        idle_cycles(6, 1'b0);
        check_output("busy_drained", 32'(busy), 0);

        // Stray beats in IDLE, then the same frame with and without invalid gaps
        threshold = 17'd1;
        apply_stimulus(1, 0, 0, 4, 0, 8, all_lanes(30000, 30000), c);
        apply_stimulus(1, 0, 1, 4, 1, 8, all_lanes(30000, 30000), c);
        idle_cycles(2, 1'b1);
        for (int col = 0; col < 3; col++) begin
            pix = all_lanes(1, 1);
            if (col == 1) pix = set_lane(pix, 3, -700, -100);
            apply_stimulus(1, col == 0, col == 2, 4, col, 8, pix, c);
            if (col != 2) idle_cycles(2, 1'b1);
        end
        push_exp(750, 4, 1, 3, 8, 3, 1, 0, c);
        data_vaild = 1'b0;
        for (int col = 0; col < 3; col++) begin
            pix = all_lanes(1, 1);
            if (col == 1) pix = set_lane(pix, 3, -700, -100);
            apply_stimulus(1, col == 0, col == 2, 4, col, 8, pix, c);
        end
        push_exp(750, 4, 1, 3, 8, 3, 1, 0, c);
        idle_cycles(6, 1'b0);

        // Reset pulse mid-frame discards the frame
        threshold = 17'd0;
        apply_stimulus(1, 1, 0, 5, 0, 3, all_lanes(20000, 0), c);
        apply_stimulus(1, 0, 0, 5, 1, 3, all_lanes(20000, 0), c);
        reset_n = 1'b0;
        #1;
        check_cleared("midreset");
        data_vaild = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle_cycles(6, 1'b0);
        apply_stimulus(1, 1, 1, 6, 2, 3, set_lane('0, 0, 0, -5), c);
        push_exp(5, 6, 2, 0, 3, 1, 1, 0, c);
        data_vaild = 1'b0;

        for (int j = 0; j < 50 && exp_q.size() != 0; j++) @(posedge clock);
        #1;
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_vec++;
            n_fail++;
            $display("[TB] FAIL missing_peak: got no peak_valid, expected one");
        end
        idle_cycles(3, 1'b0);
        check_output("busy_end", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/radar_frame_peak_detect.md
Name: radar_frame_peak_detect

Overview:
- Sits directly downstream of the pixel source that drives the radar stream bus (row/col indices, channel_num, data_start/data_end/data_vaild, 5-lane complex pixel_out).
- Per frame (data_start..data_end), computes an approximate magnitude for every complex lane of every valid beat.
- Tracks the frame peak and its location, and counts samples above a programmable threshold.
- Emits a one-cycle result record after the last beat of each frame.

Parameters:
- DATA_WIDTH, 16: width of each signed I or Q component.
- LANES, 5: complex samples per beat; pixel_out width is DATA_WIDTH*LANES*2.
- CNT_W, 16: width of the beat and detection counters (both saturating).

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_vaild  input  1  beat qualifier; all other stream inputs are ignored when low.
- data_start  input  1  first beat of frame (qualified by data_vaild).
- data_end  input  1  last beat of frame (qualified by data_vaild).
- row_idx1  input  11  row index of the beat.
- col_idx1  input  11  column index of the beat.
- channel_num  input  4  channel of the frame, latched on the start beat.
- pixel_out  input  DATA_WIDTH*LANES*2  lane k at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH]; I = low half, Q = high half; both two's complement.
- threshold  input  DATA_WIDTH+1  unsigned detection threshold, sampled per beat in stage 2.
- busy  output  1  frame open or pipeline not drained.
- peak_valid  output  1  one-cycle pulse; result fields are valid while high.
- peak_mag  output  DATA_WIDTH+1  frame maximum magnitude.
- peak_row  output  11  row of the peak beat.
- peak_col  output  11  column of the peak beat.
- peak_lane  output  3  lane index of the peak (0..LANES-1).
- peak_channel  output  4  channel_num latched at frame start.
- beat_count  output  CNT_W  valid beats in the frame.
- det_count  output  CNT_W  lanes with magnitude strictly greater than threshold.
- frame_err  output  1  frame was restarted by a second data_start.

Behaviour:
- Reset: all outputs and internal registers are 0; FSM goes to IDLE. Reset asserted mid-frame discards the frame and flushes the pipeline; no peak_valid is emitted for it.
- FSM states: IDLE, ACTIVE.
  - IDLE + (vaild & start): enter ACTIVE; clear accumulators; latch channel_num; the start beat is processed.
  - ACTIVE + (vaild & end): beat processed, return to IDLE.
  - vaild & start & end in the same beat: single-beat frame; stay in IDLE.
  - IDLE + vaild without start: beat ignored; no counter changes.
  - ACTIVE + vaild & start: discard accumulated values; restart with this beat; set a sticky err flag reported with this frame's result. The flag clears on the next start taken from IDLE.
  - data_end while IDLE without start: ignored.
- Pipeline, beat accepted at edge t:
  - Stage 1 (t+1): |I| and |Q| per lane, DATA_WIDTH-bit unsigned; |-2^(W-1)| = 2^(W-1) exactly.
  - Stage 2 (t+2): mag = max + (min>>1), DATA_WIDTH+1 bits, no overflow possible; per-lane compare against threshold.
  - Stage 3 (t+3): lane maximum, lowest lane wins ties; merge into running peak only if strictly greater, so the earliest beat wins ties; det_count += number of lanes over threshold; beat_count += 1.
  - Row, col and frame tags travel with the beat through the pipeline.
- Result: for the end beat accepted at edge t, peak_valid is high for exactly the cycle after edge t+3. All result fields hold until the next peak_valid.
- Back-to-back frames with no idle cycles are supported.
- A beat_count of 0 is impossible; a frame of all-zero pixels reports peak_mag 0, lane 0, and the first beat's row/col.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- busy = ACTIVE or any pipeline stage holding a valid beat.

Test Plan:
- Single-beat frame (start=end=1, row 3, col 7, ch 2), lane 2 = (I=-300, Q=400), others 0, threshold 100 -> peak_valid 4 cycles after the beat; peak_mag 550, lane 2, row 3, col 7, channel 2, beat_count 1, det_count 1, frame_err 0.
- 8-beat frame with col 0..7, lane 4 of col 5 = (I=-32768, Q=-32768), all other lanes (10,0), threshold 0 -> peak_mag 49152, lane 4, col 5, beat_count 8, det_count 40.
- Tie: two beats, both with lanes 1 and 3 = (1000,0) -> peak lane 1, row/col of the first beat.
- Second data_start on beat 3 of a frame, end on beat 5 -> one peak_valid only, beat_count 3, frame_err 1; the following clean frame reports frame_err 0.
- data_vaild low with garbage inputs interleaved between beats, plus stray valid beats before start -> results identical to a gap-free run; stray beats not counted.
- reset_n pulsed low for 1 cycle mid-frame -> all outputs 0 immediately; no peak_valid; next complete frame reports correctly.
